// File: rtl/fpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_seq_ctrl
//
// Sequences one floating-point operation at a time between the decode stage
// and a variable-latency FPU core. An accepted request is latched, a one-cycle
// start is issued, and the pipeline is stalled until the FPU answers (or a
// watchdog forces completion). The result is written back through a dedicated
// regfile port and its exception flags are OR-ed into a sticky register.
// A flush during the wait lets the FPU finish quietly and discards its result.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   fpu_req_i             decoded FP request, held while stall_o=1
//   fpu_op_i/op_a_i/op_b_i/rd_addr_i  operation, operands, destination
//   flush_i               kill the instruction in decode / in flight
//   fpu_start_o           one-cycle start pulse to the FPU
//   fpu_op_o/fpu_a_o/fpu_b_o  latched operation and operands for the FPU
//   fpu_done_i/fpu_result_i/fpu_flags_i  FPU completion (flags {NV,DZ,OF,UF,NX})
//   stall_o, busy_o       hold PC/decode; controller not idle
//   wb_wren_o/wb_addr_o/wb_data_o  regfile write port
//   flags_o, flags_clr_i  sticky exception flags and their clear
//   timeout_o             one-cycle pulse on forced completion
// -----------------------------------------------------------------------------
module fpu_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,  // >= 2
  parameter int CNT_W          = 7    // 2**CNT_W >= TIMEOUT_CYCLES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fpu_req_i,
  input  logic [1:0]  fpu_op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        fpu_start_o,
  output logic [1:0]  fpu_op_o,
  output logic [31:0] fpu_a_o,
  output logic [31:0] fpu_b_o,
  input  logic        fpu_done_i,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_flags_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        wb_wren_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  flags_o,
  input  logic        flags_clr_i,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_DRAIN
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      QNAN         = 32'h7FC0_0000;
  localparam logic [4:0]       FLAG_INVALID = 5'b10000;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       wb_addr_q, wb_addr_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [4:0]       cap_flags_q, cap_flags_d;
  logic [4:0]       flags_q, flags_d;

  logic             accept;
  logic             cnt_at_last;
  logic [CNT_W-1:0] cnt_inc;

  assign accept      = fpu_req_i & ~flush_i;
  assign cnt_at_last = (cnt_q == CNT_LAST);
  // Saturating increment: the counter parks at the timeout value.
  assign cnt_inc     = cnt_at_last ? cnt_q : cnt_q + CNT_W'(1);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    cap_flags_d = cap_flags_q;
    fpu_start_o = 1'b0;
    stall_o     = 1'b0;
    wb_wren_o   = 1'b0;
    timeout_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The reset term keeps every output low while reset is held.
        stall_o = accept & ~rst_i;
        if (accept) begin
          op_d    = fpu_op_i;
          a_d     = op_a_i;
          b_d     = op_b_i;
          rd_d    = rd_addr_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fpu_start_o = 1'b1;
        stall_o     = 1'b1;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        cnt_d   = cnt_inc;
        if (flush_i) begin
          state_d = S_DRAIN;
        end else if (fpu_done_i) begin
          wb_addr_d   = rd_q;
          wb_data_d   = fpu_result_i;
          cap_flags_d = fpu_flags_i;
          state_d     = S_WB;
        end else if (cnt_at_last) begin
          timeout_o   = 1'b1;
          wb_addr_d   = rd_q;
          wb_data_d   = QNAN;
          cap_flags_d = FLAG_INVALID;
          state_d     = S_WB;
        end
      end
      S_WB: begin
        // x0 is hard-wired; a flush here kills the retiring instruction.
        wb_wren_o = (rd_q != 5'd0) & ~flush_i;
        state_d   = S_IDLE;
      end
      S_DRAIN: begin
        // Only the next decoded instruction can stall us; the flushed op is
        // left to finish inside the FPU and its result is dropped.
        stall_o = fpu_req_i;
        cnt_d   = cnt_inc;
        if (fpu_done_i || cnt_at_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear first, then accumulate, so a coinciding clear keeps only the
  // retiring instruction's flags.
  always_comb begin
    flags_d = flags_q;
    if (flags_clr_i) flags_d = '0;
    if (state_q == S_WB && !flush_i) flags_d = flags_d | cap_flags_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      cap_flags_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      cap_flags_q <= cap_flags_d;
      flags_q     <= flags_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign fpu_op_o  = op_q;
  assign fpu_a_o   = a_q;
  assign fpu_b_o   = b_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;
  assign flags_o   = flags_q;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpu_seq_ctrl
//
// Directed bench for fpu_seq_ctrl (TIMEOUT_CYCLES=8). A transaction-level
// model tracks the outstanding operation by elapsed cycles since acceptance
// and predicts every output; it is compared against the DUT on each falling
// edge. Hand-computed literal checks in the stimulus pin the model itself.
// Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fpu_seq_ctrl;

  localparam int T  = 8;
  localparam int CW = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fpu_req_i;
  logic [1:0]  fpu_op_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        fpu_start_o;
  logic [1:0]  fpu_op_o;
  logic [31:0] fpu_a_o;
  logic [31:0] fpu_b_o;
  logic        fpu_done_i;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_flags_i;
  logic        stall_o;
  logic        busy_o;
  logic        wb_wren_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic [4:0]  flags_o;
  logic        flags_clr_i;
  logic        timeout_o;

  fpu_seq_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fpu_req_i    (fpu_req_i),
    .fpu_op_i     (fpu_op_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .rd_addr_i    (rd_addr_i),
    .flush_i      (flush_i),
    .fpu_start_o  (fpu_start_o),
    .fpu_op_o     (fpu_op_o),
    .fpu_a_o      (fpu_a_o),
    .fpu_b_o      (fpu_b_o),
    .fpu_done_i   (fpu_done_i),
    .fpu_result_i (fpu_result_i),
    .fpu_flags_i  (fpu_flags_i),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .wb_wren_o    (wb_wren_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .flags_o      (flags_o),
    .flags_clr_i  (flags_clr_i),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: one outstanding operation described by its age in cycles.
  // ---------------------------------------------------------------------------
  bit          m_active;   // an accepted op has not yet retired or drained
  int          m_since;    // cycles since the accept cycle (1 = start cycle)
  bit          m_killed;   // flushed while waiting; result will be dropped
  bit          m_wb;       // this cycle is the write-back cycle
  logic [1:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;
  logic [4:0]  m_wb_addr;
  logic [31:0] m_wb_data;
  logic [4:0]  m_cap;
  logic [4:0]  m_flags;

  task automatic m_reset();
    m_active = 0; m_since = 0; m_killed = 0; m_wb = 0;
    m_op = '0; m_a = '0; m_b = '0; m_rd = '0;
    m_wb_addr = '0; m_wb_data = '0; m_cap = '0; m_flags = '0;
  endtask

  // Cycles spent waiting on the FPU, capped at the watchdog limit.
  function automatic int waited();
    return (m_since - 2 > T - 1) ? T - 1 : m_since - 2;
  endfunction

  initial m_reset();

  // Model update on each rising edge, using the inputs held across the edge.
  initial forever begin
    bit acc;
    @(posedge clk_i);
    if (rst_i) begin
      m_reset();
    end else begin
      acc = m_active && m_wb && !flush_i;
      if (flags_clr_i) m_flags = acc ? m_cap : 5'd0;
      else if (acc)    m_flags = m_flags | m_cap;

      if (!m_active) begin
        if (fpu_req_i && !flush_i) begin
          m_active = 1; m_since = 1; m_killed = 0; m_wb = 0;
          m_op = fpu_op_i; m_a = op_a_i; m_b = op_b_i; m_rd = rd_addr_i;
        end
      end else if (m_wb) begin
        m_active = 0; m_wb = 0;
      end else if (m_since == 1) begin
        m_since = 2;
      end else if (m_killed) begin
        if (fpu_done_i || waited() == T - 1) m_active = 0;
        else m_since++;
      end else if (flush_i) begin
        m_killed = 1; m_since++;
      end else if (fpu_done_i) begin
        m_wb = 1; m_wb_addr = m_rd; m_wb_data = fpu_result_i; m_cap = fpu_flags_i;
      end else if (waited() == T - 1) begin
        m_wb = 1; m_wb_addr = m_rd; m_wb_data = 32'h7FC0_0000; m_cap = 5'b10000;
      end else begin
        m_since++;
      end
    end
  end

  // Compare on each falling edge.
  initial forever begin
    bit e_start, e_stall, e_busy, e_wren, e_to;
    @(negedge clk_i);
    if (rst_i) m_reset();
    e_start = 0; e_stall = 0; e_busy = 0; e_wren = 0; e_to = 0;
    if (!rst_i) begin
      if (!m_active) begin
        e_stall = fpu_req_i && !flush_i;
      end else begin
        e_busy = 1;
        if (m_wb) begin
          e_wren = (m_rd != 0) && !flush_i;
        end else if (m_since == 1) begin
          e_start = 1; e_stall = 1;
        end else if (m_killed) begin
          e_stall = fpu_req_i;
        end else begin
          e_stall = 1;
          e_to = !flush_i && !fpu_done_i && (waited() == T - 1);
        end
      end
    end
    check("m_start",   fpu_start_o, e_start);
    check("m_stall",   stall_o,     e_stall);
    check("m_busy",    busy_o,      e_busy);
    check("m_wren",    wb_wren_o,   e_wren);
    check("m_timeout", timeout_o,   e_to);
    check("m_fpu_op",  fpu_op_o,    m_op);
    check("m_fpu_a",   fpu_a_o,     m_a);
    check("m_fpu_b",   fpu_b_o,     m_b);
    check("m_wb_addr", wb_addr_o,   m_wb_addr);
    check("m_wb_data", wb_data_o,   m_wb_data);
    check("m_flags",   flags_o,     m_flags);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request in the current cycle and runs it to retirement.
  // n > 0: FPU done n cycles after start; n == 0: FPU never answers.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int n, input logic [31:0] res,
                       input logic [4:0] flg, input bit clr_at_wb, input bit exp_wren);
    fpu_req_i = 1; fpu_op_i = op; op_a_i = a; op_b_i = b; rd_addr_i = rd;
    tick();                                   // start cycle
    if (n > 0) begin
      repeat (n) tick();
      fpu_done_i = 1; fpu_result_i = res; fpu_flags_i = flg;
      tick();
      fpu_done_i = 0;
    end else begin
      repeat (T + 1) tick();
    end
    flags_clr_i = clr_at_wb;                  // write-back cycle
    @(negedge clk_i);
    check("wb_wren_in_wb", wb_wren_o, exp_wren);
    check("stall_in_wb", stall_o, 1'b0);
    tick();
    fpu_req_i = 0; flags_clr_i = 0;
  endtask

  initial begin
    rst_i = 1; fpu_req_i = 0; fpu_op_i = 0; op_a_i = 0; op_b_i = 0; rd_addr_i = 0;
    flush_i = 0; fpu_done_i = 0; fpu_result_i = 0; fpu_flags_i = 0; flags_clr_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_busy", busy_o, 1'b0);
    check("reset_stall", stall_o, 1'b0);
    check("reset_wb_data", wb_data_o, 32'h0);
    check("reset_flags", flags_o, 5'h0);
    tick();
    rst_i = 0;
    tick();

    // 1. Basic add, done 3 cycles after start.
    fpu_req_i = 1; fpu_op_i = 2'b00; op_a_i = 32'h3F80_0000; op_b_i = 32'h4000_0000; rd_addr_i = 5;
    @(negedge clk_i); check("t1_c0_stall", stall_o, 1'b1); check("t1_c0_start", fpu_start_o, 1'b0);
    tick();
    @(negedge clk_i); check("t1_c1_start", fpu_start_o, 1'b1); check("t1_c1_fpu_a", fpu_a_o, 32'h3F80_0000);
    tick(); tick();
    fpu_done_i = 1; fpu_result_i = 32'h4040_0000; fpu_flags_i = 5'b00000;
    @(negedge clk_i); check("t1_c4_stall", stall_o, 1'b1);
    tick();
    fpu_done_i = 0;
    @(negedge clk_i);
    check("t1_c5_wren", wb_wren_o, 1'b1); check("t1_c5_addr", wb_addr_o, 5'd5);
    check("t1_c5_data", wb_data_o, 32'h4040_0000); check("t1_c5_stall", stall_o, 1'b0);
    tick();
    fpu_req_i = 0;
    @(negedge clk_i); check("t1_c6_busy", busy_o, 1'b0);
    tick();

    // 2. rd = x0: no write, flags still accumulate.
    do_op(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd0, 3, 32'h4040_0000, 5'b00010, 0, 0);
    @(negedge clk_i); check("t2_flags", flags_o, 5'b00010); check("t2_wb_addr", wb_addr_o, 5'd0);
    flags_clr_i = 1; tick(); flags_clr_i = 0;
    @(negedge clk_i); check("clr_flags", flags_o, 5'b00000);

    // 3. Timeout: FPU never answers.
    fpu_req_i = 1; fpu_op_i = 2'b10; op_a_i = 32'h7F80_0000; op_b_i = 32'hFF80_0000; rd_addr_i = 12;
    tick();                       // start cycle
    repeat (7) tick();            // 7th wait cycle
    @(negedge clk_i); check("t3_no_early_timeout", timeout_o, 1'b0);
    tick();                       // 8th wait cycle
    @(negedge clk_i); check("t3_timeout", timeout_o, 1'b1);
    tick();
    @(negedge clk_i);
    check("t3_wren", wb_wren_o, 1'b1); check("t3_data", wb_data_o, 32'h7FC0_0000);
    check("t3_addr", wb_addr_o, 5'd12); check("t3_timeout_gone", timeout_o, 1'b0);
    tick();
    fpu_req_i = 0;
    @(negedge clk_i); check("t3_flags", flags_o, 5'b10000); check("t3_busy", busy_o, 1'b0);

    // 4. Flush in the 2nd wait cycle; new request presented during drain.
    fpu_req_i = 1; fpu_op_i = 2'b01; op_a_i = 32'h40A0_0000; op_b_i = 32'h3F80_0000; rd_addr_i = 7;
    tick(); tick(); tick();       // cycle 3: 2nd wait cycle
    flush_i = 1;
    @(negedge clk_i); check("t4_c3_stall", stall_o, 1'b1);
    tick();                       // cycle 4: drain, next instruction in decode
    flush_i = 0; fpu_op_i = 2'b00; op_a_i = 32'h4100_0000; op_b_i = 32'h4000_0000; rd_addr_i = 9;
    @(negedge clk_i); check("t4_c4_stall", stall_o, 1'b1); check("t4_c4_start", fpu_start_o, 1'b0);
    tick(); tick();               // cycle 6: late done for the flushed op
    fpu_done_i = 1; fpu_result_i = 32'h4120_0000; fpu_flags_i = 5'b00001;
    @(negedge clk_i); check("t4_c6_stall", stall_o, 1'b1); check("t4_c6_wren", wb_wren_o, 1'b0);
    tick();                       // cycle 7: back in idle, accepts the new op
    fpu_done_i = 0;
    @(negedge clk_i);
    check("t4_c7_stall", stall_o, 1'b1); check("t4_c7_start", fpu_start_o, 1'b0);
    check("t4_c7_wb_data_held", wb_data_o, 32'h7FC0_0000); check("t4_c7_fpu_a_old", fpu_a_o, 32'h40A0_0000);
    tick();                       // cycle 8: start
    @(negedge clk_i); check("t4_c8_start", fpu_start_o, 1'b1); check("t4_c8_fpu_a", fpu_a_o, 32'h4100_0000);
    tick(); tick();               // cycle 10: done
    fpu_done_i = 1; fpu_result_i = 32'h4120_0000; fpu_flags_i = 5'b00000;
    tick();
    fpu_done_i = 0;
    @(negedge clk_i); check("t4_wren", wb_wren_o, 1'b1); check("t4_addr", wb_addr_o, 5'd9);
    tick();
    fpu_req_i = 0;
    @(negedge clk_i); check("t4_flags", flags_o, 5'b10000);

    // 5. Back-to-back with sticky flags and a clear coinciding with write-back.
    flags_clr_i = 1; tick(); flags_clr_i = 0;
    do_op(2'b00, 32'h3F80_0000, 32'h3F80_0000, 5'd1, 1, 32'h4000_0000, 5'b00001, 0, 1);
    do_op(2'b01, 32'h4040_0000, 32'h3F80_0000, 5'd2, 5, 32'h4000_0000, 5'b00100, 0, 1);
    @(negedge clk_i); check("t5_flags_after_op2", flags_o, 5'b00101);
    do_op(2'b11, 32'h0000_0001, 32'h0000_0002, 5'd3, 2, 32'h0000_0003, 5'b01000, 1, 1);
    @(negedge clk_i); check("t5_flags_after_op3", flags_o, 5'b01000); check("t5_data", wb_data_o, 32'h3);

    // 6. Reset mid-wait, then a stray done after release.
    fpu_req_i = 1; fpu_op_i = 2'b00; op_a_i = 32'h4080_0000; op_b_i = 32'h4080_0000; rd_addr_i = 3;
    tick(); tick(); tick();       // cycle 3: waiting
    rst_i = 1; fpu_req_i = 0;
    #1;
    check("t6_rst_busy", busy_o, 1'b0); check("t6_rst_stall", stall_o, 1'b0);
    check("t6_rst_fpu_a", fpu_a_o, 32'h0); check("t6_rst_flags", flags_o, 5'h0);
    check("t6_rst_wb_data", wb_data_o, 32'h0); check("t6_rst_wb_addr", wb_addr_o, 5'h0);
    tick();
    rst_i = 0;
    tick();
    fpu_done_i = 1; fpu_result_i = 32'hDEAD_BEEF; fpu_flags_i = 5'b11111;
    @(negedge clk_i); check("t6_done_wren", wb_wren_o, 1'b0); check("t6_done_busy", busy_o, 1'b0);
    tick();
    fpu_done_i = 0;
    @(negedge clk_i); check("t6_after_flags", flags_o, 5'h0); check("t6_after_data", wb_data_o, 32'h0);
    do_op(2'b00, 32'h4080_0000, 32'h4080_0000, 5'd4, 2, 32'h4100_0000, 5'b00001, 0, 1);
    @(negedge clk_i); check("t6_next_flags", flags_o, 5'b00001); check("t6_next_data", wb_data_o, 32'h4100_0000);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_seq_ctrl.md
Name: fpu_seq_ctrl

Overview:
- Sequences multi-cycle floating-point operations between the decode stage and a variable-latency FPU core.
- Accepts a decoded FP request (the decoder's FPU-enable qualified by instruction valid), issues a one-cycle start to the FPU and stalls the pipeline until completion.
- Writes the result to the regfile through a dedicated write port, accumulates sticky exception flags, and handles flush and FPU timeout.

Parameters:
TIMEOUT_CYCLES, 64, maximum WAIT cycles before forced completion; must be >= 2.
CNT_W, 7, cycle counter width; 2**CNT_W >= TIMEOUT_CYCLES.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-high reset
fpu_req_i  input  1  FP instruction present in decode, held while stall_o=1
fpu_op_i  input  2  00 add, 01 sub, others passed through
op_a_i  input  32  rs1 operand
op_b_i  input  32  second operand (rs2 or imm)
rd_addr_i  input  5  destination register
flush_i  input  1  kill the instruction in decode/in flight
fpu_start_o  output  1  one-cycle start pulse to FPU
fpu_op_o  output  2  latched op
fpu_a_o  output  32  latched operand A
fpu_b_o  output  32  latched operand B
fpu_done_i  input  1  FPU result valid, one-cycle pulse
fpu_result_i  input  32  FPU result
fpu_flags_i  input  5  {NV,DZ,OF,UF,NX}, valid with fpu_done_i
stall_o  output  1  hold PC/decode
busy_o  output  1  state != IDLE
wb_wren_o  output  1  regfile write enable for FP result
wb_addr_o  output  5  write address
wb_data_o  output  32  write data
flags_o  output  5  sticky accumulated flags
flags_clr_i  input  1  clear sticky flags
timeout_o  output  1  one-cycle pulse on forced completion

Behaviour:
- Reset (async, rst_i=1): state IDLE, counter 0, latches 0, flags_o 0, and all outputs 0.
- States: IDLE, ISSUE, WAIT, WB, DRAIN. fpu_op_o, fpu_a_o and fpu_b_o are registered latches.
- IDLE:
  - stall_o = fpu_req_i & ~flush_i.
  - On fpu_req_i & ~flush_i: latch op, a, b, rd, then go to ISSUE.
  - fpu_req_i with flush_i is ignored.
- ISSUE:
  - fpu_start_o=1 and stall_o=1.
  - Clear counter, then go to WAIT.
  - fpu_done_i in ISSUE is ignored; the FPU minimum latency is 1 cycle after start.
- WAIT: stall_o=1 and counter increments each cycle. Priority order:
  1. flush_i -> DRAIN.
  2. fpu_done_i -> capture result and flags, then go to WB.
  3. counter == TIMEOUT_CYCLES-1 -> timeout_o=1, result 32'h7FC00000, flags 5'b10000, go to WB.
- WB:
  - stall_o=0, so the pipeline advances this cycle.
  - wb_wren_o = (rd != 0) & ~flush_i; wb_addr_o = rd; wb_data_o = captured result.
  - flags_o |= captured flags unless flush_i.
  - Then go to IDLE. The held request has retired, so the next IDLE cycle sees the next instruction only.
- DRAIN (flushed op still in FPU):
  - stall_o = fpu_req_i; no start or writeback.
  - Counter continues from its current value.
  - On fpu_done_i or counter == TIMEOUT_CYCLES-1, go to IDLE. The result is discarded and timeout_o is not pulsed.
- wb_wren_o is asserted only in WB. wb_addr_o and wb_data_o hold their last value otherwise.
- flags_clr_i: flags_o <= 0. If it coincides with a WB accumulate, flags_o <= captured flags only (clear applied first).
- The counter saturates; no wrap-around is possible because it is bounded by TIMEOUT_CYCLES-1.
- Reset mid-operation returns to IDLE immediately. No writeback occurs, and a later fpu_done_i is ignored in IDLE.
- fpu_done_i in IDLE or WB is ignored.
- Latency without contention: result is written N+2 cycles after the accept cycle, where the FPU asserts done N cycles after start.

Test Plan:
1. Basic add: reset, then req op=00, a=3F800000, b=40000000, rd=5 at cycle 0; FPU done at cycle 4 with 40400000 and flags 0.
   -> start=1 at cycle 1; stall=1 cycles 0-4; cycle 5: wb_wren=1, addr=5, data=40400000, stall=0; busy=0 at cycle 6.
2. rd=0: same op with rd=0.
   -> start pulse and stall sequence unchanged; wb_wren stays 0 in WB; flags still accumulate.
3. Timeout (TIMEOUT_CYCLES=8), FPU never done.
   -> timeout_o pulses in the 8th WAIT cycle; next cycle wb_wren=1, data=7FC00000; flags_o=10000.
4. Flush in the 2nd WAIT cycle, FPU done 3 cycles later with 41200000; a new req is presented during DRAIN.
   -> no wb_wren; stall_o=1 until done; new req accepted in the cycle after done, start one cycle later.
5. Back-to-back: op1 done with flags 00001, op2 done with flags 00100; then flags_clr_i coincides with op3's WB (flags 01000).
   -> flags_o=00101 after op2; flags_o=01000 after op3.
6. Reset asserted mid-WAIT, then FPU done pulses after reset release.
   -> all outputs 0 immediately; done ignored; no writeback; next req accepted normally.
